// File: rtl/seq_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_adder_pkg
// Description : Shared constants for the sequential chunked adder: FSM state
//               encoding and default datapath geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_adder_pkg;

    // Default geometry: 32-bit operands added 8 bits per cycle
    localparam int c_DEF_WIDTH = 32;
    localparam int c_DEF_CHUNK = 8;

    // FSM state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

endpackage : seq_adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell.
//               a, b, cin : addend bits and carry-in
//               sum, cout : sum bit and carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder
`default_nettype wire

// File: rtl/rca_chunk.sv
`default_nettype none
// ============================================================================
// Module      : rca_chunk
// Description : CHUNK-bit ripple-carry adder built from full_adder cells.
//               in1, in2 : slice operands
//               cin      : carry into the slice LSB
//               sum      : slice sum
//               cout     : carry out of the slice MSB
//               c_msb    : carry into the slice MSB (for signed overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module rca_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] in1,
    input  logic [CHUNK-1:0] in2,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (in1[i]),
            .b    (in2[i]),
            .cin  (w_carry[i]),
            .sum  (sum[i]),
            .cout (w_carry[i+1])
        );
    end

    assign cout  = w_carry[CHUNK];
    assign c_msb = w_carry[CHUNK-1];

endmodule : rca_chunk
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_adder
// Description : Multi-cycle WIDTH-bit adder/subtractor. One CHUNK-bit slice is
//               added per cycle through a shared ripple chain; the inter-slice
//               carry is held in a register.
//               in_valid/in_ready   : operand handshake (in1, in2, cin, sub)
//               out_valid/out_ready : result handshake (sum, cout, ovf)
//               busy                : operation in progress or result pending
// Revision    : 1.0 - initial release
// ============================================================================
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int CHUNK = c_DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCH     = WIDTH / CHUNK;
    localparam int c_IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NCH - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $fatal(1, "seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    // Operands and result viewed as arrays of slices so the chunk-select
    // muxes are a plain index by r_idx.
    logic [1:0]                  r_state;
    logic [NCH-1:0][CHUNK-1:0]   r_a;
    logic [NCH-1:0][CHUNK-1:0]   r_b;
    logic [NCH-1:0][CHUNK-1:0]   r_sum;
    logic [c_IDX_W-1:0]          r_idx;
    logic                        r_carry;
    logic                        r_cout;
    logic                        r_ovf;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic                        r_busy;

    logic [CHUNK-1:0]            w_slice_sum;
    logic                        w_slice_cout;
    logic                        w_slice_cmsb;

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_rca (
        .in1   (r_a[r_idx]),
        .in2   (r_b[r_idx]),
        .cin   (r_carry),
        .sum   (w_slice_sum),
        .cout  (w_slice_cout),
        .c_msb (w_slice_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b here and seed
                        // the carry with 1 so the datapath only ever adds.
                        r_a        <= in1;
                        r_b        <= sub ? ~in2 : in2;
                        r_carry    <= sub ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_CALC;
                    end
                end

                c_CALC: begin
                    r_sum[r_idx] <= w_slice_sum;
                    r_carry      <= w_slice_cout;
                    r_idx        <= r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        // Top slice: its MSB is the word MSB, so its carry
                        // in/out give the word-level cout and overflow.
                        r_cout      <= w_slice_cout;
                        r_ovf       <= w_slice_cmsb ^ w_slice_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end

                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule : seq_chunk_adder
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_chunk_adder
// Description : Self-checking bench for seq_chunk_adder. Instance 0 uses
//               WIDTH=32/CHUNK=8, instance 1 uses WIDTH=32/CHUNK=32. Results
//               are compared against a 33-bit arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

    logic        clk;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in1       [2];
    logic [31:0] in2       [2];
    logic        cin       [2];
    logic        sub       [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] sum       [2];
    logic        cout      [2];
    logic        ovf       [2];
    logic        busy      [2];

    int tests_run = 0;
    int failed    = 0;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in1(in1[0]), .in2(in2[0]), .cin(cin[0]), .sub(sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0])
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in1(in1[1]), .in2(in2[1]), .cin(cin[1]), .sub(sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain 33-bit arithmetic; overflow from operand/result signs.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb,
                         output logic [31:0] s, output logic co, output logic ov);
        logic [31:0] bb;
        logic [32:0] r;
        bb = sb ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {32'd0, (sb ? 1'b1 : ci)};
        s  = r[31:0];
        co = r[32];
        ov = (a[31] == bb[31]) && (s[31] != a[31]);
    endtask

    // Present one operation, wait for out_valid (bounded); leaves DUT in DONE.
    task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb,
                         output logic [31:0] s, output logic co, output logic ov,
                         output int lat);
        @(negedge clk);
        in_valid[d] = 1'b1; in1[d] = a; in2[d] = b; cin[d] = ci; sub[d] = sb;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        s = sum[d]; co = cout[d]; ov = ovf[d];
    endtask

    task automatic release_result(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 0; out_ready[d] = 0; in1[d] = '0; in2[d] = '0;
            cin[d] = 0; sub[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
                sum[d] !== 32'd0 || cout[d] !== 1'b0 || ovf[d] !== 1'b0) begin
                failed++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b busy=%b sum=%h co=%b ov=%b, need 1 0 0 0 0 0",
                         d, in_ready[d], out_valid[d], busy[d], sum[d], cout[d], ovf[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                32'h80000000, 32'd5, 32'd7};
        logic [31:0] vb [6] = '{32'h00000001, 32'h00000000, 32'h00000001,
                                32'h80000000, 32'd7, 32'd5};
        logic        vc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] es [6] = '{32'h00000100, 32'h00000000, 32'h80000000,
                                32'h00000000, 32'hFFFFFFFE, 32'd2};
        logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] s; logic co, ov; int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(0, va[i], vb[i], vc[i], vs[i], s, co, ov, lat);
            tests_run++;
            if (s !== es[i] || co !== ec[i] || ov !== eo[i]) begin
                failed++;
                $display("FAIL directed[%0d]: sum=%h co=%b ov=%b, need sum=%h co=%b ov=%b",
                         i, s, co, ov, es[i], ec[i], eo[i]);
            end
            tests_run++;
            if (lat != 4) begin
                failed++;
                $display("FAIL directed_latency[%0d]: %0d cycles, need 4", i, lat);
            end
            release_result(0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, s, es; logic ci, sb, co, ov, ec, eo; int lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); sb = 1'($urandom);
            if (i % 8 == 0) b = ~a;   // exercise long carry chains
            model(a, b, ci, sb, es, ec, eo);
            do_op(0, a, b, ci, sb, s, co, ov, lat);
            tests_run++;
            if (s !== es || co !== ec || ov !== eo || lat != 4) begin
                failed++;
                $display("FAIL random[%0d] %h %s %h ci=%b: sum=%h co=%b ov=%b lat=%0d, need %h %b %b 4",
                         i, a, sb ? "-" : "+", b, ci, s, co, ov, lat, es, ec, eo);
            end
            release_result(0);
        end
    endtask

    task automatic test_handshake();
        logic [31:0] s, es, held; logic ec, eo, hc, ho; int lat;
        model(32'h0F0F0F0F, 32'h01010101, 1'b1, 1'b0, es, ec, eo);
        @(negedge clk);
        in_valid[0] = 1; in1[0] = 32'h0F0F0F0F; in2[0] = 32'h01010101;
        cin[0] = 1; sub[0] = 0;
        @(posedge clk);
        @(negedge clk);
        // Keep requesting with different operands during CALC
        in1[0] = 32'hDEADBEEF; in2[0] = 32'h12345678; sub[0] = 1;
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 40) begin
            tests_run++;
            if (in_ready[0] !== 1'b0) begin
                failed++;
                $display("FAIL calc_in_ready: %b, need 0", in_ready[0]);
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        in_valid[0] = 0;
        held = sum[0]; hc = cout[0]; ho = ovf[0];
        tests_run++;
        if (held !== es || hc !== ec || ho !== eo || lat != 4) begin
            failed++;
            $display("FAIL calc_ignore_input: sum=%h co=%b ov=%b lat=%0d, need %h %b %b 4",
                     held, hc, ho, lat, es, ec, eo);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (out_valid[0] !== 1'b1 || sum[0] !== es || cout[0] !== ec || ovf[0] !== eo) begin
                failed++;
                $display("FAIL done_hold[%0d]: vld=%b sum=%h co=%b ov=%b, need 1 %h %b %b",
                         k, out_valid[0], sum[0], cout[0], ovf[0], es, ec, eo);
            end
        end
        // Release and request at the same edge: request must wait for IDLE
        in_valid[0] = 1; in1[0] = 32'h00000003; in2[0] = 32'h00000004;
        cin[0] = 0; sub[0] = 0; out_ready[0] = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 0;
        tests_run++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            failed++;
            $display("FAIL release_to_idle: vld=%b rdy=%b busy=%b, need 0 1 0",
                     out_valid[0], in_ready[0], busy[0]);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 0;
        tests_run++;
        if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            failed++;
            $display("FAIL accept_after_idle: busy=%b rdy=%b, need 1 0", busy[0], in_ready[0]);
        end
        lat = 0;
        while (out_valid[0] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        s = sum[0];
        tests_run++;
        if (s !== 32'd7 || lat != 4) begin
            failed++;
            $display("FAIL second_op: sum=%h lat=%0d, need 00000007 4", s, lat);
        end
        release_result(0);
    endtask

    task automatic test_chunk32();
        logic [31:0] a, b, s, es; logic ci, sb, co, ov, ec, eo; int lat;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); sb = 1'($urandom);
            if (i == 0) begin a = 32'h7FFFFFFF; b = 32'h00000001; ci = 0; sb = 0; end
            model(a, b, ci, sb, es, ec, eo);
            do_op(1, a, b, ci, sb, s, co, ov, lat);
            tests_run++;
            if (s !== es || co !== ec || ov !== eo || lat != 1) begin
                failed++;
                $display("FAIL chunk32[%0d]: sum=%h co=%b ov=%b lat=%0d, need %h %b %b 1",
                         i, s, co, ov, lat, es, ec, eo);
            end
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                @(negedge clk);
                tests_run++;
                if (out_valid[1] !== 1'b1 || sum[1] !== es) begin
                    failed++;
                    $display("FAIL chunk32_hold[%0d]: vld=%b sum=%h, need 1 %h",
                             i, out_valid[1], sum[1], es);
                end
            end
            release_result(1);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] s; logic co, ov; int lat;
        @(negedge clk);
        in_valid[0] = 1; in1[0] = 32'hFFFFFFAA; in2[0] = 32'h00000011;
        cin[0] = 0; sub[0] = 0;
        @(posedge clk);          // accept
        @(negedge clk);
        in_valid[0] = 0;
        @(posedge clk);          // first slice written
        #2;
        tests_run++;
        if (sum[0][7:0] !== 8'hBB || busy[0] !== 1'b1) begin
            failed++;
            $display("FAIL pre_reset_slice: sum[7:0]=%h busy=%b, need bb 1", sum[0][7:0], busy[0]);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (sum[0] !== 32'd0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
            out_valid[0] !== 1'b0 || cout[0] !== 1'b0 || ovf[0] !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: sum=%h busy=%b rdy=%b vld=%b co=%b ov=%b, need 0 0 1 0 0 0",
                     sum[0], busy[0], in_ready[0], out_valid[0], cout[0], ovf[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 32'h12345678, 32'h11111111, 1'b0, 1'b0, s, co, ov, lat);
        tests_run++;
        if (s !== 32'h23456789 || co !== 1'b0 || ov !== 1'b0 || lat != 4) begin
            failed++;
            $display("FAIL after_reset_op: sum=%h co=%b ov=%b lat=%0d, need 23456789 0 0 4",
                     s, co, ov, lat);
        end
        release_result(0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_handshake();
        test_chunk32();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule : tb_seq_chunk_adder
`default_nettype wire
